// File: rtl/merge_rr_pkg.sv
// merge_rr_pkg: interconnect field-layout macros plus types shared by merge_rr and rr_arbiter.
// Revision: 1.0
`default_nettype none

`ifndef INTERCONNECT_VH
`define INTERCONNECT_VH
`define REQ_W 26
`define RESP_W 17
`define VALID_BIT (`REQ_W-1)
`define READY_BIT 0
`define REQ_SLICE(i) ((i)*`REQ_W) +: `REQ_W
`define RESP_SLICE(i) ((i)*`RESP_W) +: `RESP_W
`endif

package merge_rr_pkg;

  localparam int REQ_W  = `REQ_W;
  localparam int RESP_W = `RESP_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/merge_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority pick, scanning upward from ptr+1 with explicit wrap.
// Revision: 1.0
`default_nettype none

module rr_arbiter
  import merge_rr_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int PW        = idx_w(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic [N_MASTERS-1:0] winner,
  output logic                 any_req
);

  always_comb begin
    logic [PW-1:0] idx;
    logic          found;
    winner = '0;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < N_MASTERS; k++) begin
      // Explicit wrap keeps non-power-of-two master counts in range.
      idx = (idx == PW'(N_MASTERS - 1)) ? '0 : idx + 1'b1;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/merge_rr.sv
// merge_rr: N-to-1 request merger; one round-robin grant at a time, response routed to the grantee.
// Revision: 1.0
`default_nettype none

module merge_rr
  import merge_rr_pkg::*;
#(
  parameter int N_MASTERS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*`REQ_W-1:0]   m_req,
  output logic [N_MASTERS*`RESP_W-1:0]  m_resp,
  output logic [`REQ_W-1:0]             s_req,
  input  logic [`RESP_W-1:0]            s_resp,
  output logic [N_MASTERS-1:0]          m_grant
);

  localparam int PW = idx_w(N_MASTERS);

  state_t                 state, state_n;
  logic [N_MASTERS-1:0]   grant_n;
  logic [N_MASTERS-1:0]   valids;
  logic [N_MASTERS-1:0]   winner;
  logic [PW-1:0]          ptr, ptr_n, win_idx;
  logic                   any_req;
  logic                   g_valid;
  logic                   s_ready;

  rr_arbiter #(.N_MASTERS(N_MASTERS), .PW(PW)) u_arb (
    .req     (valids),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  assign s_ready = s_resp[`READY_BIT];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_port
    logic [`REQ_W-1:0]  req_i;
    logic [`RESP_W-1:0] resp_i;

    assign req_i     = m_req[`REQ_SLICE(i)];
    assign valids[i] = req_i[`VALID_BIT];

    // rdata is broadcast; only the granted master ever sees ready.
    always_comb begin
      resp_i             = s_resp;
      resp_i[`READY_BIT] = s_ready && m_grant[i];
    end

    assign m_resp[`RESP_SLICE(i)] = resp_i;
  end

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (winner[k]) win_idx = PW'(k);
    end
  end

  // While BUSY the pointer is the granted master's index.
  assign g_valid = valids[ptr];

  always_comb begin
    s_req = '0;
    if (state == ST_BUSY) s_req = m_req[`REQ_SLICE(ptr)];
  end

  always_comb begin
    state_n = state;
    grant_n = m_grant;
    ptr_n   = ptr;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_n = ST_BUSY;
          grant_n = winner;
          ptr_n   = win_idx;
        end
      end
      ST_BUSY: begin
        if (s_ready || !g_valid) begin
          state_n = ST_IDLE;
          grant_n = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      m_grant <= '0;
      ptr     <= PW'(N_MASTERS - 1);
    end else begin
      state   <= state_n;
      m_grant <= grant_n;
      ptr     <= ptr_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_merge_rr.sv
// tb_merge_rr: checks merge_rr at N=2,3,4 against a transaction-level arbitration model.
// Revision: 1.0
`default_nettype none

module tb_merge_rr;
  import merge_rr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   wait_cycles;
  logic [3:0] add;
  logic [3:0] kill;
  int   errors = 0;
  int   checks = 0;
  int   hist [3][$];

  logic [2:0][3:0]        grant_obs;
  logic [2:0][3:0]        ready_obs;
  logic [2:0][REQ_W-1:0]  sreq_obs;
  logic [2:0][RESP_W-1:0] resp1_obs;
  logic [2:0]             active_obs;

  always #5 clk = ~clk;

  // Request: {valid, we, addr[7:0], wdata[15:0]}
  function automatic logic [REQ_W-1:0] mk_req(logic v, int i, int s);
    return {v, i[0], 4'(i), 4'(s), 16'(32'hA000 + i * 256 + s)};
  endfunction

  // Slave answers with {addr, ~addr} after wait_cycles of held valid.
  function automatic logic [RESP_W-1:0] slave_resp(logic [REQ_W-1:0] r, int c, int w);
    logic [7:0] a;
    a = r[23:16];
    return {a, ~a, (r[REQ_W-1] && (c == w))};
  endfunction

  function automatic int oh2i(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar K = 0; K < 3; K++) begin : g_dut
    localparam int N = K + 2;

    logic [N*REQ_W-1:0]  m_req;
    logic [N*RESP_W-1:0] m_resp;
    logic [REQ_W-1:0]    s_req;
    logic [RESP_W-1:0]   s_resp;
    logic [N-1:0]        m_grant;
    logic [N-1:0]        vld;
    logic [N-1:0]        prev_grant = '0;
    logic [3:0]          rdy;
    int pend [N];
    int seq  [N];
    int cnt;
    int mbusy, mg, mptr;

    merge_rr #(.N_MASTERS(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .m_req   (m_req),
      .m_resp  (m_resp),
      .s_req   (s_req),
      .s_resp  (s_resp),
      .m_grant (m_grant)
    );

    always_comb begin
      vld   = '0;
      m_req = '0;
      for (int i = 0; i < N; i++) begin
        vld[i] = (pend[i] > 0) && !kill[i];
        m_req[i*REQ_W +: REQ_W] = mk_req(vld[i], i, seq[i]);
      end
    end

    assign s_resp = slave_resp(s_req, cnt, wait_cycles);

    always @(posedge clk or posedge rst) begin
      if (rst) cnt <= 0;
      else if (s_req[REQ_W-1] && !s_resp[0]) cnt <= cnt + 1;
      else cnt <= 0;
    end

    // Masters hold a request until they see their ready, then move to the next one.
    always @(posedge clk or posedge rst) begin
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          pend[i] <= 0;
          seq[i]  <= 0;
        end else if (kill[i]) begin
          pend[i] <= 0;
        end else if (m_resp[i*RESP_W]) begin
          pend[i] <= pend[i] - 1 + int'(add[i]);
          seq[i]  <= seq[i] + 1;
        end else begin
          pend[i] <= pend[i] + int'(add[i]);
        end
      end
    end

    function automatic int pick(logic [N-1:0] v, int p);
      for (int j = 1; j <= N; j++) if (v[(p + j) % N]) return (p + j) % N;
      return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        mbusy <= 0;
        mg    <= 0;
        mptr  <= N - 1;
      end else if (mbusy == 0) begin
        if (pick(vld, mptr) >= 0) begin
          mbusy <= 1;
          mg    <= pick(vld, mptr);
          mptr  <= pick(vld, mptr);
        end
      end else if (!vld[mg] || s_resp[0]) begin
        mbusy <= 0;
      end
    end

    always @(negedge clk) begin
      logic [REQ_W-1:0]  exp_s;
      logic [RESP_W-1:0] exp_r;
      exp_s = (mbusy != 0) ? m_req[mg*REQ_W +: REQ_W] : '0;
      check($sformatf("grant N=%0d", N), 64'(m_grant), (mbusy != 0) ? 64'(64'd1 << mg) : 64'd0);
      check($sformatf("s_req N=%0d", N), 64'(s_req), 64'(exp_s));
      for (int i = 0; i < N; i++) begin
        if (mbusy != 0) begin
          exp_r = {s_resp[RESP_W-1:1], (i == mg) && s_resp[0]};
          check($sformatf("m_resp[%0d] N=%0d", i, N), 64'(m_resp[i*RESP_W +: RESP_W]), 64'(exp_r));
        end else begin
          check($sformatf("idle ready[%0d] N=%0d", i, N), 64'(m_resp[i*RESP_W]), 64'd0);
        end
      end
      if (m_grant != '0 && prev_grant == '0) hist[K].push_back(oh2i(4'(m_grant)));
      prev_grant <= m_grant;
    end

    always_comb begin
      rdy = '0;
      for (int i = 0; i < N; i++) rdy[i] = m_resp[i*RESP_W];
    end

    assign grant_obs[K]  = 4'(m_grant);
    assign ready_obs[K]  = rdy;
    assign sreq_obs[K]   = s_req;
    assign resp1_obs[K]  = m_resp[RESP_W +: RESP_W];
    assign active_obs[K] = (|vld) || (|m_grant);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) hist[k].delete();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (active_obs != 3'b000 && n < 300) begin
      tick();
      n++;
    end
    check("drain within budget", 64'(n < 300), 64'd1);
    tick();
  endtask

  // Grant history encoded one hex digit per grant, digit = master index + 1.
  function automatic int hcode(int k);
    int c;
    c = 0;
    for (int j = 0; j < hist[k].size(); j++) c = c * 16 + hist[k][j] + 1;
    return c;
  endfunction

  task automatic check_hist(string name, int e2, int e3, int e4);
    check($sformatf("%s order N=2", name), 64'(hcode(0)), 64'(e2));
    check($sformatf("%s order N=3", name), 64'(hcode(1)), 64'(e3));
    check($sformatf("%s order N=4", name), 64'(hcode(2)), 64'(e4));
  endtask

  initial begin
    rst = 1'b1;
    add = '0;
    kill = '0;
    wait_cycles = 0;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      check("reset grant", 64'(grant_obs[k]), 64'd0);
      check("reset s_req valid", 64'(sreq_obs[k][REQ_W-1]), 64'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) hist[k].delete();

    // Single master, slave ready after two wait cycles.
    wait_cycles = 2;
    add = 4'b0010;
    tick();
    add = '0;
    check("single arb cycle grant", 64'(grant_obs[0]), 64'h0);
    tick();
    check("single grant", 64'(grant_obs[0]), 64'h2);
    check("single s_req valid", 64'(sreq_obs[0][REQ_W-1]), 64'd1);
    tick();
    tick();
    check("single ready", 64'(ready_obs[0]), 64'h2);
    check("single resp1", 64'(resp1_obs[0]), 64'h21DF);
    tick();
    check("single back to idle", 64'(grant_obs[0]), 64'h0);
    wait_done();
    check_hist("single", 'h2, 'h2, 'h2);

    // Reset in the middle of a transaction.
    do_reset();
    wait_cycles = 10;
    add = 4'b0010;
    tick();
    add = '0;
    tick();
    tick();
    check("pre-reset grant", 64'(grant_obs[0]), 64'h2);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("mid reset grant", 64'(grant_obs[k]), 64'd0);
      check("mid reset s_req valid", 64'(sreq_obs[k][REQ_W-1]), 64'd0);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) hist[k].delete();
    wait_cycles = 0;
    add = 4'b0011;
    tick();
    add = '0;
    wait_done();
    check_hist("post reset", 'h12, 'h12, 'h12);

    // Full contention, two requests per master.
    do_reset();
    wait_cycles = 0;
    add = 4'b1111;
    tick();
    tick();
    add = '0;
    wait_done();
    check_hist("contention", 'h1212, 'h123123, 'h12341234);

    // Wrap from the last master back to 0.
    do_reset();
    add = 4'b0101;
    tick();
    add = '0;
    wait_done();
    check_hist("wrap", 'h1, 'h13, 'h13);

    // Long wait states with a competing request arriving mid-transaction.
    do_reset();
    wait_cycles = 10;
    add = 4'b0010;
    tick();
    add = '0;
    tick();
    repeat (3) tick();
    add = 4'b0001;
    tick();
    add = '0;
    tick();
    tick();
    check("wait grant held", 64'(grant_obs[2]), 64'h2);
    check("wait s_req exact", 64'(sreq_obs[2]), 64'h310A100);
    check("wait no ready", 64'(ready_obs[2]), 64'h0);
    wait_done();
    check_hist("wait", 'h21, 'h21, 'h21);

    // Granted master drops valid without a response.
    do_reset();
    wait_cycles = 10;
    add = 4'b1100;
    tick();
    add = '0;
    tick();
    tick();
    tick();
    kill = 4'b0100;
    #1;
    check("abort no ready", 64'(ready_obs[2]), 64'h0);
    check("abort s_req valid", 64'(sreq_obs[2][REQ_W-1]), 64'd0);
    tick();
    kill = '0;
    check("abort idle N=4", 64'(grant_obs[2]), 64'h0);
    check("abort idle N=3", 64'(grant_obs[1]), 64'h0);
    tick();
    check("abort next grant", 64'(grant_obs[2]), 64'h8);
    wait_done();
    check_hist("abort", 0, 'h3, 'h34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/merge_rr.md
Name: merge_rr

Overview:
- N-to-1 request merger with round-robin arbitration; the inverse of the address split.
- Collects native-interface requests from N_MASTERS masters and forwards exactly one at a time to a single slave port.
- Routes the slave response back to the granted master only.
- Sits between multiple CPU/DMA masters and a shared memory or peripheral bus segment.

Parameters:
- N_MASTERS, 2, number of master ports; legal range ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- m_req  input  N_MASTERS*`REQ_W  concatenated master requests; master i occupies slice `req(i).
- m_resp  output  N_MASTERS*`RESP_W  concatenated master responses; master i occupies slice `resp(i).
- s_req  output  `REQ_W  request to the shared slave.
- s_resp  input  `RESP_W  response from the shared slave.
- m_grant  output  N_MASTERS  one-hot grant, visible for debug/verification.

Behaviour:
- Request field layout: valid is the MSB of each request. Response field layout: ready is the LSB of each response, rdata occupies the remaining bits.
- FSM states:
  - IDLE: no grant. s_req = all-zero (valid=0). All m_resp ready bits = 0.
  - BUSY: one master is granted.
- Reset (async, rst=1): state=IDLE; m_grant=0; last-granted pointer=N_MASTERS-1, so master 0 has highest priority after reset. All outputs take their IDLE values immediately.
- Arbitration in IDLE:
  - Candidates are masters with valid=1.
  - Winner is the first candidate found scanning upward from pointer+1, modulo N_MASTERS.
  - At the next clk edge: m_grant <= onehot(winner), pointer <= winner, state <= BUSY.
  - No valid request: remain in IDLE.
- BUSY, granted master g:
  - s_req = m_req[`req(g)], combinational pass-through, valid included.
  - m_resp[`resp(g)] = s_resp, combinational.
  - Every other m_resp slice: rdata = s_resp rdata, ready=0.
  - Leaving BUSY: when s_resp ready=1, or when master g's valid=0 (abort/protocol violation), the next edge gives state <= IDLE and m_grant <= 0.
- Latency:
  - Valid asserted in cycle t while IDLE → s_req valid in cycle t+1.
  - Response is zero-cycle from the slave: ready in cycle r reaches master g in cycle r.
  - Return to IDLE at r+1. Minimum back-to-back spacing is 2 cycles per transaction (one arbitration bubble).
- Masters must hold valid and all request fields stable from assertion until the cycle their ready is seen.
- Requests arriving while BUSY wait; they are never dropped.
- Simultaneous events:
  - Ready and a new valid from another master in the same cycle: the new request is arbitrated in the following IDLE cycle.
  - A master that keeps valid high after its ready is treated as issuing a new request and competes normally. Rotation guarantees the other masters are served first.
- Fairness: with all N masters requesting continuously, each is granted exactly once per N grants.
- Reset mid-transaction: the grant is dropped immediately and s_req valid=0. The slave must tolerate the aborted access.
- Indices: pointer and winner are $clog2(N_MASTERS) bits. Wrap from N_MASTERS-1 to 0 is explicit, so N_MASTERS need not be a power of two.

Decomposition:
- interconnect.vh (shared) holds `REQ_W, `RESP_W, `req(i), `resp(i), and new macros `VALID_BIT=`REQ_W-1 and `READY_BIT=0. No local field-position literals.
- One sub-module: rr_arbiter.
  - Combinational rotating-priority winner: inputs are request vector and pointer; outputs are one-hot winner and any_req.
  - merge_rr owns the FSM, grant/pointer registers and datapath muxing.

Test Plan:
- Reset: assert rst mid-BUSY (master 1 granted) → same cycle s_req valid=0, m_grant=0; after release, master 0 and master 1 both requesting → master 0 granted first.
- Single master: N=2, master 1 valid at cycle 5, slave ready at cycle 8 → m_grant=2'b10 at 6, m_resp[1] ready=1 at 8 with matching rdata, m_resp[0] ready=0 throughout, IDLE at 9.
- Contention: N=4, all valid continuously, slave ready one cycle after each grant → grant order 0,1,2,3,0,1…; every master served once per 4 grants.
- Non-power-of-two wrap: N=3, pointer=2, masters 0 and 2 valid → master 0 wins; next arbitration with only 2 valid → master 2 wins.
- Wait states: slave holds ready=0 for 10 cycles → s_req equals the granted master's req bit-exact every cycle; master 0 request arriving meanwhile is not forwarded until the current transaction completes.
- Abort: granted master drops valid without ready → IDLE next cycle, no response pulse to any master, pending requests arbitrated normally.
